// File: rtl/rec_deframer_pkg.sv
// Shared types for the record deframer: subtype enum, header field positions,
// FSM states and decoded-record struct. CHK state exists only with REC_DEFRAMER_CHKSUM_EN.
package rec_deframer_pkg;

    typedef enum logic [2:0] {
        STATE_0       = 3'd0,
        STATE_F0      = 3'd1,
        STATE_244     = 3'd2,
        STATE_DEFAULT = 3'd3
    } subtype_e;

    localparam int HDR_MODE_LSB = 5;
    localparam int HDR_RSVD_LSB = 3;
    localparam int HDR_SUB_LSB  = 0;

    typedef enum logic [2:0] {
        ST_HDR = 3'd0,
        ST_LEN = 3'd1,
        ST_PAY = 3'd2,
`ifdef REC_DEFRAMER_CHKSUM_EN
        ST_CHK = 3'd3,
`endif
        ST_OUT = 3'd4
    } fsm_e;

    typedef struct packed {
        logic [2:0] mode;
        subtype_e   subtype;
        logic [7:0] len;
        logic       err;
    } rec_t;

    // Header is malformed when the subtype is 4..7 or the reserved bits are set.
    function automatic logic hdr_bad(input logic [7:0] hdr);
        return hdr[HDR_SUB_LSB + 2] | (hdr[HDR_RSVD_LSB +: 2] != 2'b00);
    endfunction

endpackage

// File: rtl/rec_deframer_chk.sv
// XOR checksum accumulator for the record deframer; compares the running
// XOR against the incoming checksum byte.
module rec_deframer_chk (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       upd,
    input  logic [7:0] in_byte,
    output logic       bad
);

    logic [7:0] acc_r;

    // Accumulator restarts on the header byte and folds in length/payload bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 8'h00;
        end else if (load) begin
            acc_r <= in_byte;
        end else if (upd) begin
            acc_r <= acc_r ^ in_byte;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign bad = (acc_r != in_byte);

endmodule

// File: rtl/rec_deframer.sv
// Record deframer: header/length/payload(/checksum) byte stream to one decoded record.
// Optional checksum byte enabled by macro REC_DEFRAMER_CHKSUM_EN.
module rec_deframer
    import rec_deframer_pkg::*;
#(
    parameter int MAX_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [2:0]           m_mode,
    output subtype_e             m_subtype,
    output logic [7:0]           m_len,
    output logic [8*MAX_LEN-1:0] m_data,
    output logic                 m_err
);

    fsm_e                 state_r;
    fsm_e                 state_nxt_s;
    rec_t                 rec_r;
    logic [8*MAX_LEN-1:0] data_r;
    logic [7:0]           cnt_r;
    logic                 valid_r;
    logic                 acc_s;
    logic                 last_pay_s;

    assign s_ready    = rst_n & (state_r != ST_OUT);
    assign acc_s      = s_valid & s_ready;
    assign last_pay_s = ((cnt_r + 8'd1) == rec_r.len);

`ifdef REC_DEFRAMER_CHKSUM_EN
    localparam fsm_e ST_TAIL = ST_CHK;
    logic chk_bad_s;

    rec_deframer_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (acc_s && (state_r == ST_HDR)),
        .upd     (acc_s && ((state_r == ST_LEN) || (state_r == ST_PAY))),
        .in_byte (s_data),
        .bad     (chk_bad_s)
    );
`else
    localparam fsm_e ST_TAIL = ST_OUT;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HDR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; bytes advance the FSM only when accepted.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HDR: begin
                if (acc_s) state_nxt_s = ST_LEN;
                else       state_nxt_s = ST_HDR;
            end
            ST_LEN: begin
                if (acc_s) state_nxt_s = (s_data != 8'd0) ? ST_PAY : ST_TAIL;
                else       state_nxt_s = ST_LEN;
            end
            ST_PAY: begin
                if (acc_s && last_pay_s) state_nxt_s = ST_TAIL;
                else                     state_nxt_s = ST_PAY;
            end
`ifdef REC_DEFRAMER_CHKSUM_EN
            ST_CHK: begin
                if (acc_s) state_nxt_s = ST_OUT;
                else       state_nxt_s = ST_CHK;
            end
`endif
            ST_OUT: begin
                if (m_ready) state_nxt_s = ST_HDR;
                else         state_nxt_s = ST_OUT;
            end
            default: state_nxt_s = ST_HDR;
        endcase
    end

    // Record capture; fields freeze while the record is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_r   <= '0;
            data_r  <= '0;
            cnt_r   <= 8'd0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_HDR: begin
                    if (acc_s) begin
                        rec_r.mode    <= s_data[HDR_MODE_LSB +: 3];
                        rec_r.subtype <= subtype_e'(s_data[HDR_SUB_LSB +: 3]);
                        rec_r.len     <= 8'd0;
                        rec_r.err     <= hdr_bad(s_data);
                        cnt_r         <= 8'd0;
                    end
                end
                ST_LEN: begin
                    if (acc_s) begin
                        rec_r.len <= s_data;
                        rec_r.err <= rec_r.err | (s_data > 8'(MAX_LEN));
                    end
                end
                ST_PAY: begin
                    if (acc_s) begin
                        // Bytes beyond MAX_LEN are consumed but never stored.
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (cnt_r == 8'(i)) data_r[8*i +: 8] <= s_data;
                        end
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
`ifdef REC_DEFRAMER_CHKSUM_EN
                ST_CHK: begin
                    if (acc_s) rec_r.err <= rec_r.err | chk_bad_s;
                end
`endif
                ST_OUT: begin
                    if (m_ready) begin
                        valid_r <= 1'b0;
                        data_r  <= '0;
                    end
                end
                default: ;
            endcase
            if ((state_nxt_s == ST_OUT) && (state_r != ST_OUT)) begin
                valid_r <= 1'b1;
            end
        end
    end

    assign m_valid   = valid_r;
    assign m_mode    = rec_r.mode;
    assign m_subtype = rec_r.subtype;
    assign m_len     = rec_r.len;
    assign m_data    = data_r;
    assign m_err     = rec_r.err;

endmodule

// File: tb/tb_rec_deframer.sv
// Table-driven bench for rec_deframer (MAX_LEN=4), with directed sequences for
// back-pressure and mid-frame reset. Follows REC_DEFRAMER_CHKSUM_EN if defined.
module tb_rec_deframer;

    localparam int MAX_LEN = 4;
`ifdef REC_DEFRAMER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [2:0]  m_mode;
    logic [2:0]  m_subtype;
    logic [7:0]  m_len;
    logic [31:0] m_data;
    logic        m_err;

    int n_cmp = 0;
    int n_bad = 0;

    rec_deframer #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_mode    (m_mode),
        .m_subtype (m_subtype),
        .m_len     (m_len),
        .m_data    (m_data),
        .m_err     (m_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:9][7:0] b;
        int              n;
        logic            bad_chk;
        logic [2:0]      mode;
        logic [2:0]      sub;
        logic [7:0]      len;
        logic [31:0]     data;
        logic            err;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic [0:9][7:0] b, input int n, input logic bad,
                                input logic [2:0] mode, input logic [2:0] sub,
                                input logic [7:0] len, input logic [31:0] data, input logic err);
        vec_t v;
        v.b = b; v.n = n; v.bad_chk = bad; v.mode = mode; v.sub = sub;
        v.len = len; v.data = data; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive bytes with s_valid held high; each wait for s_ready is bounded.
    task automatic send_bytes(input logic [0:9][7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            s_data  = b[i];
            s_valid = 1'b1;
            while (!s_ready && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!s_ready) check("accept_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        logic [0:9][7:0] fb;
        int              n;
        logic [7:0]      x;
        fb = v.b;
        n  = v.n;
        if (CHK_EN) begin
            x = 8'h00;
            for (int i = 0; i < v.n; i++) x = x ^ v.b[i];
            fb[n] = v.bad_chk ? (x ^ 8'h01) : x;
            n++;
        end
        send_bytes(fb, n);
    endtask

    task automatic check_record(input vec_t v, input string tag);
        check({tag, "_valid"},   {63'd0, m_valid},   64'd1);
        check({tag, "_mode"},    {61'd0, m_mode},    {61'd0, v.mode});
        check({tag, "_subtype"}, {61'd0, m_subtype}, {61'd0, v.sub});
        check({tag, "_len"},     {56'd0, m_len},     {56'd0, v.len});
        check({tag, "_data"},    {32'd0, m_data},    {32'd0, v.data});
        check({tag, "_err"},     {63'd0, m_err},     {63'd0, v.err | (CHK_EN & v.bad_chk)});
    endtask

    // Consume the record: s_ready is low in OUT, high again right after.
    task automatic release_record(input string tag);
        check({tag, "_sready_out"}, {63'd0, s_ready}, 64'd0);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check({tag, "_valid_clr"}, {63'd0, m_valid}, 64'd0);
        check({tag, "_sready_hdr"}, {63'd0, s_ready}, 64'd1);
        check({tag, "_data_clr"}, {32'd0, m_data}, 64'd0);
    endtask

    initial begin
        vec_t       a;
        vec_t       bfr;
        logic [31:0] held;
        int          seen;

        vecs[0] = mk({8'h41, 8'h02, 8'hAA, 8'h55, 48'h0}, 4, 1'b0, 3'd2, 3'd1, 8'd2, 32'h0000_55AA, 1'b0);
        vecs[1] = mk({8'h41, 8'h02, 8'hAA, 8'h55, 48'h0}, 4, 1'b1, 3'd2, 3'd1, 8'd2, 32'h0000_55AA, 1'b0);
        vecs[2] = mk({8'h07, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 16'h0}, 8, 1'b0,
                     3'd0, 3'd7, 8'd6, 32'h0403_0201, 1'b1);
        vecs[3] = mk({8'h20, 8'h00, 64'h0}, 2, 1'b0, 3'd1, 3'd0, 8'd0, 32'h0, 1'b0);
        vecs[4] = mk({8'h18, 8'h01, 8'hFF, 56'h0}, 3, 1'b0, 3'd0, 3'd0, 8'd1, 32'h0000_00FF, 1'b1);
        vecs[5] = mk({8'hE3, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 32'h0}, 6, 1'b0,
                     3'd7, 3'd3, 8'd4, 32'h4433_2211, 1'b0);
        vecs[6] = mk({8'h02, 8'h03, 8'h10, 8'h20, 8'h30, 40'h0}, 5, 1'b0,
                     3'd0, 3'd2, 8'd3, 32'h0030_2010, 1'b0);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_sready", {63'd0, s_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, m_valid}, 64'd0);
        check("rst_err", {63'd0, m_err}, 64'd0);
        check("rst_mode", {61'd0, m_mode}, 64'd0);
        check("rst_subtype", {61'd0, m_subtype}, 64'd0);
        check("rst_len", {56'd0, m_len}, 64'd0);
        check("rst_data", {32'd0, m_data}, 64'd0);
        #2 rst_n = 1'b1;
        #1;
        check("rst_sready_release", {63'd0, s_ready}, 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i]);
            check_record(vecs[i], $sformatf("row%0d", i));
            release_record($sformatf("row%0d", i));
        end

        // Back-pressure: record held 5 cycles, next header waits
        a   = vecs[0];
        bfr = vecs[6];
        send_frame(a);
        check_record(a, "bp_rec1");
        held    = m_data;
        s_data  = bfr.b[0];
        s_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_sready_c%0d", c), {63'd0, s_ready}, 64'd0);
            check($sformatf("bp_stable_c%0d", c), {31'd0, m_valid, m_data}, {32'd1, held});
            @(posedge clk); #1;
        end
        check("bp_rec1_err", {63'd0, m_err}, 64'd0);
        release_record("bp_rel");
        send_frame(bfr);
        check_record(bfr, "bp_rec2");
        release_record("bp_rec2");

        // Reset after the 2nd payload byte of an N=3 frame
        send_bytes({8'h41, 8'h03, 8'hAA, 8'h55, 48'h0}, 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sready", {63'd0, s_ready}, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        check("mid_rst_sready_release", {63'd0, s_ready}, 64'd1);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (m_valid) seen++;
        end
        check("mid_rst_no_valid", 64'(seen), 64'd0);
        send_frame(vecs[5]);
        check_record(vecs[5], "post_rst");
        release_record("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rec_deframer.md
REC_DEFRAMER -- requirements
Module: rec_deframer

Interface
REQ-001 Parameter MAX_LEN, default 4, SHALL set the maximum payload bytes stored per record (range 1..8).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 s_data  input  8  SHALL carry the inbound frame byte.
REQ-005 s_valid  input  1  SHALL mark s_data valid.
REQ-006 s_ready  output  1  SHALL indicate a byte is accepted this cycle when s_valid is also high.
REQ-007 m_valid  output  1  SHALL mark the decoded record valid.
REQ-008 m_ready  input  1  SHALL indicate the consumer takes the record this cycle when m_valid is high.
REQ-009 m_mode  output  3  SHALL carry the decoded mode field.
REQ-010 m_subtype  output  3  SHALL carry the decoded subtype as the shared 3-bit state enum.
REQ-011 m_len  output  8  SHALL carry the received length byte unmodified.
REQ-012 m_data  output  8*MAX_LEN  SHALL carry payload, byte i in bits [8i+7:8i], with unused bytes zero.
REQ-013 m_err  output  1  SHALL flag a malformed record, valid only while m_valid is high.

Function
REQ-014 Frame format SHALL be: header {mode[7:5], rsvd[4:3], subtype[2:0]}, length byte N, N payload bytes, then a checksum byte when checksum checking is compiled in.
REQ-015 FSM states SHALL be HDR, LEN, PAY, CHK, OUT; a byte is consumed only on s_valid && s_ready.
REQ-016 Transitions SHALL be: HDR->LEN on header; LEN->PAY if N>0, else ->CHK (or ->OUT without checksum); PAY->CHK/OUT after the Nth byte; CHK->OUT on the checksum byte; OUT->HDR on m_ready.
REQ-017 s_ready SHALL be 1 in HDR, LEN, PAY and CHK, and 0 in OUT.
REQ-018 m_valid SHALL assert in the cycle after the final frame byte is accepted, and SHALL hold with all m_* outputs stable until m_ready.
REQ-019 OUT->HDR SHALL take one cycle, so back-to-back frames incur exactly one s_ready-low cycle when m_ready is already high.
REQ-020 The payload byte counter SHALL be 8 bits; payload bytes with index >= MAX_LEN SHALL be consumed but discarded.
REQ-021 m_err SHALL be set if the subtype is 4..7, if rsvd != 0, if N > MAX_LEN, or on checksum mismatch; the fields are still output as received.
REQ-022 N = 0 SHALL yield m_data = 0 with no PAY cycles.
REQ-023 m_data SHALL be cleared when HDR is entered, so no bytes from the previous record leak into the next.

Reset
REQ-024 Reset SHALL force state HDR, m_valid=0, m_err=0, m_mode=0, m_subtype=0 (STATE_0), m_len=0, m_data=0, the counter to 0 and the checksum accumulator to 0.
REQ-025 Reset asserted mid-frame or while in OUT SHALL drop the partial or pending record; decoding resumes at the next byte, which is treated as a header.
REQ-026 s_ready SHALL be 0 while rst_n is low, and 1 in the first cycle after release.

Configuration
REQ-027 Macro REC_DEFRAMER_CHKSUM_EN defined: a CHK byte SHALL be expected, equal to the XOR of the header, length and all payload bytes, and a mismatch SHALL set m_err.
REQ-028 Macro REC_DEFRAMER_CHKSUM_EN undefined: the CHK state and the XOR accumulator SHALL be absent, and PAY (or LEN when N = 0) SHALL go directly to OUT.

Structure
REQ-029 The shared package SHALL hold the 3-bit subtype enum (STATE_0, STATE_F0, STATE_244, STATE_DEFAULT), the header field positions, the FSM state enum and a decoded-record packed struct.
REQ-030 One sub-module, rec_deframer_chk (XOR accumulator plus compare), SHALL be instantiated only under REC_DEFRAMER_CHKSUM_EN.

Verification
REQ-031 Scenario 1 (CHKSUM_EN): bytes 0x41,0x02,0xAA,0x55,0xBC -> m_mode=2, m_subtype=1, m_len=2, m_data=0x0000_55AA, m_err=0.
REQ-032 Scenario 2: same frame with checksum 0xBD -> identical fields with m_err=1.
REQ-033 Scenario 3: header 0x07, N=6, six payload bytes 1..6 -> m_data=0x04030201, m_err=1, all bytes consumed, and the next frame decodes correctly.
REQ-034 Scenario 4: two back-to-back frames with m_ready held low 5 cycles -> s_ready=0 for those cycles, record 1 stable, record 2 bytes unaccepted until the OUT->HDR cycle.
REQ-035 Scenario 5: header 0x20, N=0 -> m_data=0, m_len=0, m_valid one cycle after the last byte.
REQ-036 Scenario 6: rst_n pulsed low after the 2nd payload byte -> no m_valid, and a following complete frame decodes with m_err=0.
